mux_2to1_arbiter: RTL
=====================

Name: mux_2to1_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 data mux between two requesters using valid/ready handshakes.
- Sequences the mux select and loads the winning word into a registered output stage.
- Sits between two producer streams and a single downstream consumer.
- Fairness is per word.
- Packet-level locking is added by the optional macro.

Parameters:
- DATA_W, 8, width of each requester word and of y_out.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- i0_data  input  DATA_W  requester 0 word.
- i0_valid  input  1  requester 0 word available.
- i0_ready  output  1  requester 0 word accepted this cycle.
- i1_data  input  DATA_W  requester 1 word.
- i1_valid  input  1  requester 1 word available.
- i1_ready  output  1  requester 1 word accepted this cycle.
- y_out  output  DATA_W  registered output word.
- y_valid  output  1  y_out holds a valid word.
- y_ready  input  1  downstream accepts y_out.
- select_n  output  1  registered source of the word in y_out (0 = i0, 1 = i1).

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on rising clk.
  - Clears y_out=0, y_valid=0, select_n=0.
  - Sets internal last_grant=1, so requester 0 wins the first tie.
  - Returns the FSM to ARB.
  - Asserting rst mid-operation discards any held word; no handshake completes in the reset cycle.
- Output stage:
  - load_en = !y_valid || y_ready.
  - Full throughput: one word per cycle when the consumer is always ready.
- Grant, combinational within the cycle, in ARB state:
  - Only one requester valid: grant that one.
  - Both valid: grant the requester opposite last_grant.
  - Neither valid: no grant.
- Ready and transfer:
  - ix_ready = load_en && grant==x, for exactly one x at most.
  - An ix_ready is never asserted while rst=1.
  - A transfer occurs when ix_valid && ix_ready.
- On transfer, at the next edge:
  - y_out <= ix_data.
  - y_valid <= 1.
  - select_n <= x.
  - last_grant <= x.
  - Latency: input to y_out is 1 cycle.
- load_en with no transfer: y_valid <= 0 and y_out holds its value.
- !load_en (y_valid=1, y_ready=0):
  - y_out, y_valid and select_n hold.
  - Both readies are 0.
  - last_grant does not change.
- Requester rules:
  - A requester must hold ix_data stable while ix_valid=1 and ix_ready=0.
  - The arbiter never drops a valid word.
- Simultaneous events: downstream accept and a new load in the same cycle is a normal back-to-back transfer.
- FSM:
  - Without the macro, the FSM stays in ARB permanently.
  - States: ARB, LOCK0, LOCK1. LOCK0 and LOCK1 are used only with the macro.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- Defined:
  - Adds ports i0_last and i1_last (input, 1 bit each), marking the final word of a packet.
  - ARB: a transfer from x with ix_last=0 moves the FSM to LOCKx.
  - LOCKx: only x may be granted; the other requester's ready stays 0 even if it is valid.
  - LOCKx: a transfer from x with ix_last=1 returns the FSM to ARB.
  - last_grant updates as normal.
  - A single-word packet (last=1 on the first word) does not leave ARB.
- Undefined:
  - No last ports exist.
  - The FSM stays in ARB.
  - Arbitration is per word.

Test Plan:
- Reset, then i0_valid=i1_valid=1 with i0_data=8'hA0..A3 and i1_data=8'hB0..B3, y_ready=1 -> y_out sequence A0,B0,A1,B1,... with select_n 0,1,0,1; first y_valid one cycle after the first i0_ready.
- Only i1_valid=1, data 8'h11,8'h22,8'h33, y_ready=1 -> i1_ready=1 every cycle; y_out 11,22,33 on consecutive cycles; select_n=1; i0_ready=0.
- y_ready=0 for 3 cycles while y_valid=1 with y_out=8'h5A -> y_out stays 5A, both readies 0, last_grant unchanged; when y_ready=1 the next word loads on the following edge.
- Pulse rst=1 for one cycle while y_valid=1 and both requesters valid -> next cycle y_valid=0, y_out=0, select_n=0; after release requester 0 is granted first.
- ARB_PKT_LOCK_EN: i0 sends a 3-word packet C0,C1,C2 (last on C2) while i1 is valid with D0 -> y_out C0,C1,C2,D0; i1_ready=0 until C2 transfers.
- Idle gap: both valid=0 for 2 cycles with y_ready=1 -> y_valid drops to 0 one cycle after the last transfer; y_out holds its last value.

Source files
------------

// File: rtl/mux_2to1_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_2to1_arbiter
// Description : Round-robin valid/ready arbiter that feeds one 2:1 data mux
//               into a registered output stage. Per-word fairness by default.
//               Define ARB_PKT_LOCK_EN to hold the grant until a packet's last word.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_2to1_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i0_data,
  input  logic              i0_valid,
  output logic              i0_ready,
  input  logic [DATA_W-1:0] i1_data,
  input  logic              i1_valid,
  output logic              i1_ready,
`ifdef ARB_PKT_LOCK_EN
  input  logic              i0_last,
  input  logic              i1_last,
`endif
  output logic [DATA_W-1:0] y_out,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              select_n
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic [DATA_W-1:0]   r_y_out;
  logic                r_y_valid;
  logic                r_select;

  logic                w_load_en;
  logic                w_gnt_vld;
  logic                w_gnt_sel;
  logic                w_xfer;
  logic [DATA_W-1:0]   w_xfer_data;

  assign w_load_en = !r_y_valid || y_ready;

  // Grant: a tie goes to the requester that did not win last time.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_sel = 1'b0;
    case (r_state)
      ARB: begin
        if (i0_valid && i1_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt_sel = ~r_last_grant;
        end else if (i0_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt_sel = 1'b0;
        end else if (i1_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt_sel = 1'b1;
        end
      end
      LOCK0: begin
        w_gnt_vld = i0_valid;
        w_gnt_sel = 1'b0;
      end
      LOCK1: begin
        w_gnt_vld = i1_valid;
        w_gnt_sel = 1'b1;
      end
      default: begin
        w_gnt_vld = 1'b0;
        w_gnt_sel = 1'b0;
      end
    endcase
  end

  assign w_xfer      = !rst && w_load_en && w_gnt_vld;
  assign i0_ready    = w_xfer && !w_gnt_sel;
  assign i1_ready    = w_xfer &&  w_gnt_sel;
  assign w_xfer_data = w_gnt_sel ? i1_data : i0_data;

`ifdef ARB_PKT_LOCK_EN
  logic w_xfer_last;
  assign w_xfer_last = w_gnt_sel ? i1_last : i0_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB: begin
        if (w_xfer && !w_xfer_last)
          w_state_nxt = w_gnt_sel ? LOCK1 : LOCK0;
      end
      LOCK0, LOCK1: begin
        if (w_xfer && w_xfer_last)
          w_state_nxt = ARB;
      end
      default: w_state_nxt = ARB;
    endcase
  end
`else
  always_comb begin
    w_state_nxt = ARB;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB;
      r_last_grant <= 1'b1;
      r_y_out      <= '0;
      r_y_valid    <= 1'b0;
      r_select     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_en) begin
        if (w_xfer) begin
          r_y_out      <= w_xfer_data;
          r_y_valid    <= 1'b1;
          r_select     <= w_gnt_sel;
          r_last_grant <= w_gnt_sel;
        end else begin
          r_y_valid    <= 1'b0;
        end
      end
    end
  end

  assign y_out    = r_y_out;
  assign y_valid  = r_y_valid;
  assign select_n = r_select;

endmodule
`default_nettype wire
